// File: rtl/bcpu_regfile_wr_ctrl.sv
// Write-port controller for the barrel-CPU register file: zero-clears every entry after reset,
// then arbitrates ALU writeback, buffered load returns and debug writes onto one port.
module bcpu_regfile_wr_ctrl #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned LD_FIFO_DEPTH  = 4,
    parameter int unsigned STARVE_LIMIT   = 8
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      ALU_WR_EN,
    input  logic [REG_ADDR_WIDTH-1:0] ALU_WR_ADDR,
    input  logic [DATA_WIDTH-1:0]     ALU_WR_DATA,
    input  logic                      LD_VALID,
    output logic                      LD_READY,
    input  logic [REG_ADDR_WIDTH-1:0] LD_ADDR,
    input  logic [DATA_WIDTH-1:0]     LD_DATA,
    input  logic                      DBG_REQ,
    input  logic [REG_ADDR_WIDTH-1:0] DBG_ADDR,
    input  logic [DATA_WIDTH-1:0]     DBG_WDATA,
    output logic                      DBG_ACK,
    output logic                      INIT_BUSY,
    output logic                      REG_WR_EN,
    output logic [REG_ADDR_WIDTH-1:0] WR_REG_ADDR,
    output logic [DATA_WIDTH-1:0]     WR_REG_DATA
);

    localparam int unsigned PtrW  = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int unsigned WaitW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WaitW-1:0]          StarveMax = WaitW'(STARVE_LIMIT);
    localparam logic [REG_ADDR_WIDTH-1:0] ClrLast   = '1;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic [REG_ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [REG_ADDR_WIDTH-1:0]   r_fifo_addr [LD_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]       r_fifo_data [LD_FIFO_DEPTH];
    logic [PtrW:0]               r_wr_ptr;
    logic [PtrW:0]               r_rd_ptr;
    logic                        r_dbg_ack;
    logic [WaitW-1:0]            r_dbg_wait;

    logic [PtrW-1:0] w_wr_idx;
    logic [PtrW-1:0] w_rd_idx;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_dbg_elig;
    logic            w_starved;
    logic            w_dbg_grant;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_wr_idx   = r_wr_ptr[PtrW-1:0];
    assign w_rd_idx   = r_rd_ptr[PtrW-1:0];
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) && (w_wr_idx == w_rd_idx);
    assign LD_READY   = (r_state == StRun) && !w_full;
    assign w_push     = LD_VALID && LD_READY;
    assign w_dbg_elig = DBG_REQ && !r_dbg_ack;
    assign w_starved  = (r_dbg_wait >= StarveMax);
    assign DBG_ACK    = r_dbg_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_dbg_grant = 1'b0;
        INIT_BUSY   = 1'b0;
        REG_WR_EN   = 1'b0;
        WR_REG_ADDR = '0;
        WR_REG_DATA = '0;
        case (r_state)
            StInit: begin
                INIT_BUSY   = 1'b1;
                REG_WR_EN   = 1'b1;
                WR_REG_ADDR = r_clr_cnt;
                if (r_clr_cnt == ClrLast) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (ALU_WR_EN) begin
                    REG_WR_EN   = 1'b1;
                    WR_REG_ADDR = ALU_WR_ADDR;
                    WR_REG_DATA = ALU_WR_DATA;
                end else if (w_dbg_elig && w_starved) begin
                    w_dbg_grant = 1'b1;
                    REG_WR_EN   = 1'b1;
                    WR_REG_ADDR = DBG_ADDR;
                    WR_REG_DATA = DBG_WDATA;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    REG_WR_EN   = 1'b1;
                    WR_REG_ADDR = r_fifo_addr[w_rd_idx];
                    WR_REG_DATA = r_fifo_data[w_rd_idx];
                end else if (w_dbg_elig) begin
                    w_dbg_grant = 1'b1;
                    REG_WR_EN   = 1'b1;
                    WR_REG_ADDR = DBG_ADDR;
                    WR_REG_DATA = DBG_WDATA;
                end
            end
            default: w_state_nxt = StInit;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= StInit;
            r_clr_cnt  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_dbg_ack  <= 1'b0;
            r_dbg_wait <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dbg_ack <= w_dbg_grant;
            if (r_state == StInit) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Count only denials in run mode; saturate so the override stays armed.
            if (w_dbg_grant) begin
                r_dbg_wait <= '0;
            end else if ((r_state == StRun) && w_dbg_elig && !w_starved) begin
                r_dbg_wait <= r_dbg_wait + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_addr[w_wr_idx] <= LD_ADDR;
            r_fifo_data[w_wr_idx] <= LD_DATA;
        end
    end

endmodule

// File: tb/tb_bcpu_regfile_wr_ctrl.sv
// Self-checking bench for bcpu_regfile_wr_ctrl: direct timing checks plus an ordered
// scoreboard of expected register-file writes.
module tb_bcpu_regfile_wr_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 5;

    logic          CLK;
    logic          RESET_N;
    logic          ALU_WR_EN;
    logic [AW-1:0] ALU_WR_ADDR;
    logic [DW-1:0] ALU_WR_DATA;
    logic          LD_VALID;
    logic          LD_READY;
    logic [AW-1:0] LD_ADDR;
    logic [DW-1:0] LD_DATA;
    logic          DBG_REQ;
    logic [AW-1:0] DBG_ADDR;
    logic [DW-1:0] DBG_WDATA;
    logic          DBG_ACK;
    logic          INIT_BUSY;
    logic          REG_WR_EN;
    logic [AW-1:0] WR_REG_ADDR;
    logic [DW-1:0] WR_REG_DATA;

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;
    logic [AW+DW-1:0] q_exp[$];

    bcpu_regfile_wr_ctrl #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
        .LD_FIFO_DEPTH (4),
        .STARVE_LIMIT  (8)
    ) u_dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .ALU_WR_EN  (ALU_WR_EN),
        .ALU_WR_ADDR(ALU_WR_ADDR),
        .ALU_WR_DATA(ALU_WR_DATA),
        .LD_VALID   (LD_VALID),
        .LD_READY   (LD_READY),
        .LD_ADDR    (LD_ADDR),
        .LD_DATA    (LD_DATA),
        .DBG_REQ    (DBG_REQ),
        .DBG_ADDR   (DBG_ADDR),
        .DBG_WDATA  (DBG_WDATA),
        .DBG_ACK    (DBG_ACK),
        .INIT_BUSY  (INIT_BUSY),
        .REG_WR_EN  (REG_WR_EN),
        .WR_REG_ADDR(WR_REG_ADDR),
        .WR_REG_DATA(WR_REG_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [AW+DW-1:0] ld_exp(input int j);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = AW'(8 + (j % 8));
        d = DW'(16'h4000 + j);
        return {a, d};
    endfunction

    // Expects to be entered at posedge+1 with the clear counter at 0.
    task automatic clear_seq(input string tag);
        logic [23:0] exp;
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            exp = {1'b1, 1'b1, 1'b0, AW'(i), 16'h0000};
            check_eq(tag, {INIT_BUSY, REG_WR_EN, LD_READY, WR_REG_ADDR, WR_REG_DATA}, 64'(exp));
            tick();
        end
    endtask

    // Scoreboard: every observed write in run mode must match the next expected one.
    always @(negedge CLK) begin
        if (mon_en && REG_WR_EN) begin
            if (q_exp.size() == 0) begin
                check_eq("unexpected_wr", 64'(REG_WR_EN), 64'd0);
            end else begin
                check_eq("sb_wr", 64'({WR_REG_ADDR, WR_REG_DATA}), 64'(q_exp.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; ALU_WR_EN = 1'b0; ALU_WR_ADDR = '0; ALU_WR_DATA = '0;
        LD_VALID = 1'b0; LD_ADDR = '0; LD_DATA = '0;
        DBG_REQ = 1'b0; DBG_ADDR = '0; DBG_WDATA = '0;
        tick();
        tick();
        RESET_N = 1'b1;

        // Clear after reset, then idle in run mode.
        clear_seq("clr");
        @(negedge CLK);
        check_eq("idle_after_clr", {INIT_BUSY, REG_WR_EN, LD_READY}, 3'b001);

        // Reset at clear address 13 restarts from 0; ALU and debug are ignored during the clear.
        tick();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        @(negedge CLK);
        check_eq("clr_at13", {REG_WR_EN, WR_REG_ADDR}, {1'b1, 5'd13});
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        ALU_WR_EN = 1'b1; ALU_WR_ADDR = 5'd7; ALU_WR_DATA = 16'hFFFF;
        DBG_REQ = 1'b1; DBG_ADDR = 5'd3; DBG_WDATA = 16'h1111;
        clear_seq("clr_restart");
        ALU_WR_EN = 1'b0; DBG_REQ = 1'b0;
        @(negedge CLK);
        check_eq("idle_after_restart", {INIT_BUSY, REG_WR_EN, DBG_ACK}, 3'b000);

        // ALU and load in the same cycle: ALU first, load on the next cycle.
        mon_en = 1'b1;
        tick();
        ALU_WR_EN = 1'b1; ALU_WR_ADDR = 5'd5; ALU_WR_DATA = 16'h1234;
        LD_VALID = 1'b1; LD_ADDR = 5'd9; LD_DATA = 16'hBEEF;
        q_exp.push_back({5'd5, 16'h1234});
        @(negedge CLK);
        check_eq("alu_first", {REG_WR_EN, WR_REG_ADDR}, {1'b1, 5'd5});
        tick();
        ALU_WR_EN = 1'b0; LD_VALID = 1'b0;
        q_exp.push_back({5'd9, 16'hBEEF});
        @(negedge CLK);
        check_eq("ld_next", {REG_WR_EN, WR_REG_ADDR, WR_REG_DATA}, {1'b1, 5'd9, 16'hBEEF});
        tick();
        @(negedge CLK);
        check_eq("idle_after_ld", REG_WR_EN, 1'b0);

        // ALU busy every cycle while 5 loads arrive: FIFO fills at 4, then drains in order.
        tick();
        for (int k = 0; k < 5; k++) begin
            ALU_WR_EN = 1'b1; ALU_WR_ADDR = AW'(k); ALU_WR_DATA = DW'(16'hA000 + k);
            LD_VALID = 1'b1; LD_ADDR = AW'(24 + k); LD_DATA = DW'(16'hC000 + k);
            q_exp.push_back({AW'(k), DW'(16'hA000 + k)});
            @(negedge CLK);
            check_eq("ld_ready_fill", LD_READY, k < 4);
            tick();
        end
        for (int d = 0; d < 5; d++) begin
            ALU_WR_EN = 1'b0;
            LD_VALID = (d < 2);
            q_exp.push_back({AW'(24 + d), DW'(16'hC000 + d)});
            @(negedge CLK);
            check_eq("ld_ready_drain", LD_READY, d != 0);
            tick();
        end
        LD_VALID = 1'b0;
        @(negedge CLK);
        check_eq("idle_after_drain", REG_WR_EN, 1'b0);

        // Debug write with nothing else pending: one write, ACK on the next cycle only.
        tick();
        DBG_REQ = 1'b1; DBG_ADDR = 5'd31; DBG_WDATA = 16'h00A5;
        q_exp.push_back({5'd31, 16'h00A5});
        @(negedge CLK);
        check_eq("dbg_grant", {REG_WR_EN, DBG_ACK}, 2'b10);
        tick();
        @(negedge CLK);
        check_eq("dbg_ack_one_wr", {REG_WR_EN, DBG_ACK}, 2'b01);
        tick();
        DBG_REQ = 1'b0;
        @(negedge CLK);
        check_eq("dbg_ack_pulse", {REG_WR_EN, DBG_ACK}, 2'b00);

        // Load stream starves debug: granted after 8 denials, ahead of the FIFO head.
        tick();
        DBG_ADDR = 5'd2; DBG_WDATA = 16'h0D0D;
        for (int c = 0; c < 16; c++) begin
            LD_VALID = (c <= 13);
            LD_ADDR = ld_exp(c)[AW+DW-1:DW];
            LD_DATA = ld_exp(c)[DW-1:0];
            DBG_REQ = (c >= 1) && (c <= 10);
            if (c >= 1 && c <= 8) q_exp.push_back(ld_exp(c - 1));
            else if (c == 9) q_exp.push_back({5'd2, 16'h0D0D});
            else if (c >= 10) q_exp.push_back(ld_exp(c - 2));
            @(negedge CLK);
            if (c <= 13) check_eq("ld_ready_stream", LD_READY, 1'b1);
            if (c == 8) check_eq("dbg_denied_8", {WR_REG_ADDR, DBG_ACK}, {ld_exp(7)[AW+DW-1:DW], 1'b0});
            if (c == 9) check_eq("dbg_starve_grant", {REG_WR_EN, WR_REG_ADDR}, {1'b1, 5'd2});
            if (c == 10) check_eq("dbg_starve_ack", DBG_ACK, 1'b1);
            tick();
        end
        LD_VALID = 1'b0; DBG_REQ = 1'b0;
        @(negedge CLK);
        check_eq("idle_final", {REG_WR_EN, DBG_ACK}, 2'b00);
        check_eq("sb_empty", 64'(q_exp.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
